// File: rtl/tron_pkg.sv
// Shared definitions for the trail reader: screen geometry, RAM word layout,
// player bit constants, reader state encoding and address helpers.
package tron_pkg;

   localparam int LARGURA_TELA = 640;   // screen width, also the RAM row stride
   localparam int ALTURA_TELA  = 480;   // screen height
   localparam int TAM_BLOCO    = 8;     // block edge in pixels
   localparam int ADDR_W       = 19;    // trail RAM address width
   localparam int DATA_W       = 8;     // one trail bit per player
   localparam int COORD_W      = 10;    // screen coordinate width
   localparam int CNT_W        = $clog2(TAM_BLOCO);

   localparam logic [DATA_W-1:0] BIT_JOGADOR1 = 8'b0000_0001;
   localparam logic [DATA_W-1:0] BIT_JOGADOR2 = 8'b1000_0000;

   typedef enum logic [1:0] {
      OCIOSO,
      EMITE,
      DRENA,
      RESPOSTA
   } estado_leitor_t;

   // Plain reference address of pixel (x, y); kept simple for model use.
   function automatic logic [ADDR_W-1:0] endereco_pixel(input int x, input int y);
      return ADDR_W'(y * LARGURA_TELA + x);
   endfunction

   // y * LARGURA_TELA built as a sum of shifted copies of y, one per set bit
   // of the constant (y<<9 + y<<7 for 640), so no multiplier is inferred.
   function automatic logic [ADDR_W-1:0] vezes_largura(input logic [COORD_W-1:0] y);
      logic [ADDR_W-1:0] acc;
      acc = '0;
      for (int i = 0; i < ADDR_W; i++) begin
         if (LARGURA_TELA[i]) acc = acc + (ADDR_W'(y) << i);
      end
      return acc;
   endfunction

endpackage

// File: rtl/gerador_endereco_bloco.sv
// Row-major address walker for one TAM_BLOCO x TAM_BLOCO screen block.
// Loads the block base address once, then steps +1 along a row and jumps to
// the start of the next row at each row end. Flags the last cell of the block.
module gerador_endereco_bloco
   import tron_pkg::*;
(
   input  logic               CLOCK_50,
   input  logic               reset_n,
   input  logic               carrega,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  logic               avanca,
   output logic [ADDR_W-1:0]  endereco,
   output logic               ultimo
);

   // From the last column of a row to the first column of the next row.
   localparam logic [ADDR_W-1:0] SALTO_LINHA = ADDR_W'(LARGURA_TELA - TAM_BLOCO + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX     = CNT_W'(TAM_BLOCO - 1);

   logic [CNT_W-1:0] coluna;
   logic [CNT_W-1:0] linha;

   assign ultimo = (coluna == CNT_MAX) && (linha == CNT_MAX);

   // Address and row/column counters: load on accept, step on each issued read.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      if (!reset_n) begin
         endereco <= '0;
         coluna   <= '0;
         linha    <= '0;
      end else if (carrega) begin
         endereco <= vezes_largura(y) + ADDR_W'(x);
         coluna   <= '0;
         linha    <= '0;
      end else if (avanca) begin
         if (coluna == CNT_MAX) begin
            coluna   <= '0;
            linha    <= linha + 1'b1;
            endereco <= endereco + SALTO_LINHA;
         end else begin
            coluna   <= coluna + 1'b1;
            endereco <= endereco + 1'b1;
         end
      end
   end

endmodule

// File: rtl/leitor_rastro.sv
// Trail reader: on request, scans the 8x8 block at a candidate head position
// in the trail RAM (one read per clock) and reports whether any masked trail
// bit is set, or whether the block lies off-screen.
// Optional build macro LEITOR_RASTRO_ABORTA_EN: stop issuing reads at the
// first masked hit, drain outstanding reads, then respond.
module leitor_rastro
   import tron_pkg::*;
#(
   parameter int LAT_RAM = 2            // RAM read latency, legal range 1..4
) (
   input  logic               CLOCK_50,
   input  logic               reset_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [COORD_W-1:0] req_x,
   input  logic [COORD_W-1:0] req_y,
   input  logic [DATA_W-1:0]  req_mask,
   output logic               rd_en,
   output logic [ADDR_W-1:0]  rd_addr,
   input  logic [DATA_W-1:0]  rd_data,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic               resp_colisao,
   output logic               resp_fora
);

   estado_leitor_t     estado;
   estado_leitor_t     proximo;
   logic [DATA_W-1:0]  mascara;
   logic               acerto;
   logic               fora;
   logic [LAT_RAM-1:0] em_voo;       // rd_en delayed to line up with rd_data
   logic               fora_agora;
   logic               acerto_agora;
   logic               carrega;
   logic               avanca;
   logic               ultimo;

   // Bounds test at 11 bits so x or y near 1023 cannot wrap into range.
   assign fora_agora = (11'(req_x) + 11'(TAM_BLOCO) > 11'(LARGURA_TELA)) ||
                       (11'(req_y) + 11'(TAM_BLOCO) > 11'(ALTURA_TELA));

   // A masked bit in a word whose read slot is valid right now.
   assign acerto_agora = em_voo[LAT_RAM-1] && (|(rd_data & mascara));

   assign resp_colisao = resp_valid && acerto;
   assign resp_fora    = resp_valid && fora;

   gerador_endereco_bloco u_gerador (
      .CLOCK_50 (CLOCK_50),
      .reset_n  (reset_n),
      .carrega  (carrega),
      .x        (req_x),
      .y        (req_y),
      .avanca   (avanca),
      .endereco (rd_addr),
      .ultimo   (ultimo)
   );

   // State register.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) estado <= OCIOSO;
      else          estado <= proximo;
   end

   // Next state and handshake/strobe outputs.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // one unassigned, which would infer a latch.
      proximo    = estado;
      req_ready  = 1'b0;
      rd_en      = 1'b0;
      resp_valid = 1'b0;
      carrega    = 1'b0;
      avanca     = 1'b0;
      case (estado)
         OCIOSO: begin
            req_ready = 1'b1;
            if (req_valid) begin
               carrega = 1'b1;
               // Off-screen blocks pass through DRENA with nothing in flight,
               // which places their response one edge after the accept.
               proximo = fora_agora ? DRENA : EMITE;
            end
         end
         EMITE: begin
            rd_en  = 1'b1;
            avanca = !ultimo;
            if (ultimo) proximo = DRENA;
`ifdef LEITOR_RASTRO_ABORTA_EN
            if (acerto_agora) proximo = DRENA;
`endif
         end
         DRENA: begin
            if (em_voo == '0) proximo = RESPOSTA;
         end
         RESPOSTA: begin
            resp_valid = 1'b1;
            if (resp_ready) proximo = OCIOSO;
         end
         default: proximo = OCIOSO;
      endcase
   end

   // Request capture, read-valid pipeline and hit accumulation.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      // NOTE: the valid pipeline is cleared on reset so read data still in
      // flight from an abandoned scan is never scored.
      if (!reset_n) begin
         mascara <= '0;
         acerto  <= 1'b0;
         fora    <= 1'b0;
         em_voo  <= '0;
      end else begin
         em_voo <= (em_voo << 1) | LAT_RAM'(rd_en);
         if (carrega) begin
            mascara <= req_mask;
            acerto  <= 1'b0;
            fora    <= fora_agora;
         end else if (acerto_agora) begin
            acerto <= 1'b1;
         end
      end
   end

endmodule

// File: doc/leitor_rastro.md
Name: leitor_rastro

Overview:
- Read-side companion to the player's trail writer.
- On request, scans the 8x8 screen block at a candidate head position in the trail RAM, one read per clock.
- Reports whether any cell carries a trail bit selected by a mask, or whether the block lies off-screen.
- Sits between the player FSM (requester) and the trail RAM read port, on the CLOCK_50 domain.

Parameters:
- LARGURA_TELA, 640, screen width in pixels; RAM row stride.
- ALTURA_TELA, 480, screen height in pixels.
- TAM_BLOCO, 8, block edge in pixels (block is TAM_BLOCO x TAM_BLOCO).
- LAT_RAM, 2, RAM read latency in clocks (rd_addr/rd_en registered to rd_data valid); legal range 1..4.
- ADDR_W, 19, RAM address width.
- DATA_W, 8, RAM word width (one bit per player).

Ports:
- CLOCK_50  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_x  in  10  block top-left x.
- req_y  in  10  block top-left y.
- req_mask  in  DATA_W  trail bits that count as a hit.
- rd_en  out  1  RAM read strobe.
- rd_addr  out  ADDR_W  RAM read address.
- rd_data  in  DATA_W  RAM read data, LAT_RAM clocks after rd_en.
- resp_valid  out  1  result available.
- resp_ready  in  1  requester consumes the result.
- resp_colisao  out  1  at least one masked bit was found set.
- resp_fora  out  1  block is out of screen bounds.

Behaviour:
- Reset (asynchronous on reset_n low):
  - State returns to OCIOSO.
  - req_ready=1; rd_en=0; rd_addr=0; resp_valid=0; resp_colisao=0; resp_fora=0.
  - Any in-flight scan is abandoned; late rd_data is ignored.
- State OCIOSO:
  - req_ready=1.
  - Handshake on req_valid&&req_ready: latch x, y, mask; clear the hit accumulator.
  - If req_x+TAM_BLOCO > LARGURA_TELA or req_y+TAM_BLOCO > ALTURA_TELA, evaluated at 11-bit width so there is no wrap: go to RESPOSTA with fora=1, colisao=0. No reads are issued.
  - Otherwise go to EMITE.
- State EMITE:
  - req_ready=0.
  - rd_en=1 for exactly TAM_BLOCO^2 consecutive clocks (64 by default).
  - Address order is row-major. The first address is y*LARGURA_TELA + x.
  - Compute the first address once at accept using shifts/adds (y<<9 + y<<7 for 640). No per-cycle multiply.
  - Advance by +1 within a row, and by +(LARGURA_TELA-TAM_BLOCO+1) at the end of each row.
  - A column counter (3 bits) and a row counter (3 bits) wrap 7->0.
  - After the last issue, go to DRENA.
- Valid tracking:
  - A LAT_RAM-deep shift register carries rd_en.
  - When its tail is 1, hit |= |(rd_data & mask).
- State DRENA:
  - rd_en=0.
  - Wait until the shift register is empty (exactly LAT_RAM clocks), then go to RESPOSTA.
- State RESPOSTA:
  - resp_valid=1; resp_colisao and resp_fora are held stable.
  - On resp_ready=1, clear resp_valid and go to OCIOSO. req_ready rises on the following clock.
- Latency, default parameters, in-bounds request:
  - Accept edge is edge 0.
  - rd_en is high on clocks 1..64.
  - resp_valid rises at edge 65+LAT_RAM (67).
  - Out-of-bounds request: resp_valid rises at edge 1.
- Boundary rules:
  - x=632, y=472 is in bounds (last legal block); x=633 is out of bounds.
  - mask=0 always yields colisao=0.
  - resp_ready held high gives back-to-back operation. Minimum spacing between accepts is 1 RESPOSTA clock plus 1 OCIOSO clock.
  - req_valid is ignored outside OCIOSO.
  - rd_data outside valid slots is ignored.

Optional Feature:
- Macro: LEITOR_RASTRO_ABORTA_EN.
- Defined:
  - On the first valid masked hit, stop issuing reads: rd_en=0 from the next clock.
  - Drain outstanding reads (still LAT_RAM clocks after the last issue), then respond with colisao=1.
  - The earliest possible response for a hit on the first cell arrives at edge 1+LAT_RAM+(reads issued meanwhile drained)+1.
- Undefined: all TAM_BLOCO^2 reads are always issued; latency is fixed as above.

Decomposition:
- Package tron_pkg holds:
  - LARGURA_TELA, ALTURA_TELA, TAM_BLOCO, ADDR_W, DATA_W.
  - Player bit constants: BIT_JOGADOR1=8'b00000001, BIT_JOGADOR2=8'b10000000.
  - State enum estado_leitor_t {OCIOSO, EMITE, DRENA, RESPOSTA}.
  - Function endereco_pixel(x,y) for testbench reference use.
- One sub-module, gerador_endereco_bloco, is natural. It handles base address computation, row/column counters, row-stride jump and a last-issue flag.

Test Plan:
- Empty RAM, req x=216, y=240, mask=01 -> 64 rd_en pulses; addresses 153816..153823, then 154456..; resp at edge 67 with colisao=0, fora=0.
- RAM[(247*640)+223]=01, same request, mask=01 -> colisao=1. With mask=80 -> colisao=0.
- req x=633, y=100 -> no rd_en; resp at edge 1 with fora=1, colisao=0. x=632, y=472 -> 64 reads, fora=0.
- Hold resp_ready=0 for 10 clocks after resp -> resp_valid and flags stable, req_ready=0, second req_valid ignored. Then resp_ready=1 -> next request accepted 2 clocks later.
- Drop reset_n at issue 30 of a scan -> outputs immediately at reset values. After release, a new request completes normally, with no contamination from stale rd_data.
- LEITOR_RASTRO_ABORTA_EN defined, RAM[216+240*640]=01 -> rd_en deasserts after LAT_RAM+1 issues; resp colisao=1 well before edge 67.
